// File: rtl/commit_trace_buffer_pkg.sv
// Shared types for the retire-trace capture block: record kinds, FSM states, record layout.
// The record carries a cycle stamp only when TRACE_CYCLE_STAMP_EN is defined.
package commit_trace_pkg;

  localparam int TRACE_DATA_W = 16;
  localparam int TRACE_ADDR_W = 16;
  localparam int TRACE_REG_W  = 4;
  localparam int TRACE_CNT_W  = 32;

  typedef enum logic [2:0] {
    KIND_NOP   = 3'd0,
    KIND_REG   = 3'd1,
    KIND_LOAD  = 3'd2,
    KIND_STORE = 3'd3,
    KIND_HALT  = 3'd4
  } trace_kind_t;

  typedef enum logic [1:0] {
    S_RUN,
    S_DRAIN,
    S_DONE
  } fsm_t;

  typedef struct packed {
    trace_kind_t              kind;
    logic [TRACE_CNT_W-1:0]  inum;
    logic [TRACE_ADDR_W-1:0] pc;
    logic [TRACE_REG_W-1:0]  dstReg;
    logic [TRACE_DATA_W-1:0] value;
    logic [TRACE_ADDR_W-1:0] addr;
`ifdef TRACE_CYCLE_STAMP_EN
    logic [TRACE_CNT_W-1:0]  cycle;
`endif
  } trace_rec_t;

  // Conflicting flags (e.g. load and store together) resolve purely by this order.
  function automatic trace_kind_t classify(input logic isHalt, input logic isStore,
                                           input logic isLoad, input logic isRegWr);
    if (isHalt)                return KIND_HALT;
    else if (isStore)          return KIND_STORE;
    else if (isLoad && isRegWr) return KIND_LOAD;
    else if (isRegWr)          return KIND_REG;
    return KIND_NOP;
  endfunction

endpackage

// File: rtl/commit_trace_buffer_if.sv
// Commit-side and trace-side bus of the retire-trace buffer.
// trace_cycle exists only when TRACE_CYCLE_STAMP_EN is defined.
interface commit_trace_buffer_if;
  import commit_trace_pkg::*;

  logic                    commit_valid;
  logic [TRACE_ADDR_W-1:0] commit_pc;
  logic                    reg_write;
  logic [TRACE_REG_W-1:0]  write_reg;
  logic [TRACE_DATA_W-1:0] write_data;
  logic                    mem_read;
  logic                    mem_write;
  logic [TRACE_ADDR_W-1:0] mem_addr;
  logic [TRACE_DATA_W-1:0] mem_data;
  logic                    halt;

  logic                    trace_valid;
  logic                    trace_ready;
  logic [2:0]              trace_kind;
  logic [TRACE_CNT_W-1:0]  trace_inum;
  logic [TRACE_ADDR_W-1:0] trace_pc;
  logic [TRACE_REG_W-1:0]  trace_reg;
  logic [TRACE_DATA_W-1:0] trace_value;
  logic [TRACE_ADDR_W-1:0] trace_addr;
`ifdef TRACE_CYCLE_STAMP_EN
  logic [TRACE_CNT_W-1:0]  trace_cycle;
`endif

  modport master (
    output commit_valid, commit_pc, reg_write, write_reg, write_data,
           mem_read, mem_write, mem_addr, mem_data, halt, trace_ready,
    input  trace_valid, trace_kind, trace_inum, trace_pc, trace_reg,
           trace_value, trace_addr
`ifdef TRACE_CYCLE_STAMP_EN
    , input trace_cycle
`endif
  );

  modport slave (
    input  commit_valid, commit_pc, reg_write, write_reg, write_data,
           mem_read, mem_write, mem_addr, mem_data, halt, trace_ready,
    output trace_valid, trace_kind, trace_inum, trace_pc, trace_reg,
           trace_value, trace_addr
`ifdef TRACE_CYCLE_STAMP_EN
    , output trace_cycle
`endif
  );

endinterface

// File: rtl/commit_trace_buffer_fifo.sv
// Synchronous FIFO for trace records; a push into a full FIFO is accepted only
// when a pop happens in the same cycle. Storage is not reset, only pointers/level.
module trace_fifo #(
  parameter  int WIDTH = 8,
  parameter  int DEPTH = 16,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int LVL_W = PTR_W + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty,
  output logic [LVL_W-1:0] level
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wrPtr, rdPtr;
  logic [LVL_W-1:0] count;
  logic             pushOk, popOk;

  assign empty  = (count == '0);
  assign full   = (count == LVL_W'(DEPTH));
  assign popOk  = pop && !empty;
  assign pushOk = push && (!full || popOk);
  assign rdata  = mem[rdPtr];
  assign level  = count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wrPtr <= '0;
      rdPtr <= '0;
      count <= '0;
    end else begin
      if (pushOk) wrPtr <= wrPtr + PTR_W'(1);
      if (popOk)  rdPtr <= rdPtr + PTR_W'(1);
      count <= count + LVL_W'(pushOk) - LVL_W'(popOk);
    end
  end

  always_ff @(posedge clk) begin
    if (pushOk) mem[wrPtr] <= wdata;
  end

endmodule

// File: rtl/commit_trace_buffer.sv
// Retire-trace capture: classifies commits, tags INUMs, queues records, runs a cycle watchdog.
// Define TRACE_CYCLE_STAMP_EN to stamp each record with cycle_count and expose trace_cycle.
module commit_trace_buffer
  import commit_trace_pkg::*;
#(
  parameter  int DATA_W      = TRACE_DATA_W,
  parameter  int ADDR_W      = TRACE_ADDR_W,
  parameter  int REG_W       = TRACE_REG_W,
  parameter  int CNT_W       = TRACE_CNT_W,
  parameter  int DEPTH       = 16,
  parameter  int CYCLE_LIMIT = 100000,
  localparam int LVL_W       = $clog2(DEPTH) + 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  commit_trace_buffer_if.slave  tr,
  output logic [CNT_W-1:0]      inst_count,
  output logic [CNT_W-1:0]      cycle_count,
  output logic [LVL_W-1:0]      fifo_level,
  output logic                  overflow,
  output logic                  timeout,
  output logic                  done
);

  fsm_t              state, stateNext;
  logic [CNT_W-1:0]  instCount, cycleCount;
  logic              overflowQ, timeoutQ, timeoutSet;
  logic              commitNow, haltCommit, limitHit;
  logic              fifoFull, fifoEmpty, popFire, traceValid;
  trace_kind_t       kind;
  logic [REG_W-1:0]  recReg;
  logic [DATA_W-1:0] recValue;
  logic [ADDR_W-1:0] recAddr;
  trace_rec_t        pushRec, headRec;
  logic [$bits(trace_rec_t)-1:0] fifoRdata;

  assign commitNow  = tr.commit_valid && (state == S_RUN);
  assign haltCommit = commitNow && tr.halt;
  assign limitHit   = (state == S_RUN) && (cycleCount == CNT_W'(CYCLE_LIMIT - 1));

  always_comb begin
    kind     = classify(tr.halt, tr.mem_write, tr.mem_read, tr.reg_write);
    recReg   = '0;
    recValue = '0;
    recAddr  = '0;
    case (kind)
      KIND_REG:   begin recReg = tr.write_reg; recValue = tr.write_data; end
      KIND_LOAD:  begin recReg = tr.write_reg; recValue = tr.write_data; recAddr = tr.mem_addr; end
      KIND_STORE: begin recValue = tr.mem_data; recAddr = tr.mem_addr; end
      default:    ;
    endcase
    pushRec        = '0;
    pushRec.kind   = kind;
    pushRec.inum   = instCount;
    pushRec.pc     = tr.commit_pc;
    pushRec.dstReg = recReg;
    pushRec.value  = recValue;
    pushRec.addr   = recAddr;
`ifdef TRACE_CYCLE_STAMP_EN
    pushRec.cycle  = cycleCount;
`endif
  end

  trace_fifo #(.WIDTH($bits(trace_rec_t)), .DEPTH(DEPTH)) uFifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (commitNow),
    .wdata (pushRec),
    .pop   (popFire),
    .rdata (fifoRdata),
    .full  (fifoFull),
    .empty (fifoEmpty),
    .level (fifo_level)
  );

  // Trace fields read as zero whenever no record is offered.
  assign headRec        = fifoRdata;
  assign traceValid     = !fifoEmpty && (state != S_DONE);
  assign popFire        = traceValid && tr.trace_ready;
  assign tr.trace_valid = traceValid;
  assign tr.trace_kind  = traceValid ? headRec.kind   : '0;
  assign tr.trace_inum  = traceValid ? headRec.inum   : '0;
  assign tr.trace_pc    = traceValid ? headRec.pc     : '0;
  assign tr.trace_reg   = traceValid ? headRec.dstReg : '0;
  assign tr.trace_value = traceValid ? headRec.value  : '0;
  assign tr.trace_addr  = traceValid ? headRec.addr   : '0;
`ifdef TRACE_CYCLE_STAMP_EN
  assign tr.trace_cycle = traceValid ? headRec.cycle  : '0;
`endif

  always_comb begin
    stateNext  = state;
    timeoutSet = 1'b0;
    case (state)
      S_RUN: begin
        if (haltCommit) begin
          stateNext = S_DRAIN;
        end else if (limitHit) begin
          stateNext  = S_DRAIN;
          timeoutSet = 1'b1;
        end
      end
      S_DRAIN: if (fifoEmpty) stateNext = S_DONE;
      default: stateNext = S_DONE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_RUN;
      instCount  <= '0;
      cycleCount <= '0;
      overflowQ  <= 1'b0;
      timeoutQ   <= 1'b0;
    end else begin
      state <= stateNext;
      if (commitNow)       instCount  <= instCount + CNT_W'(1);
      if (state == S_RUN)  cycleCount <= cycleCount + CNT_W'(1);
      if (commitNow && fifoFull && !popFire) overflowQ <= 1'b1;
      if (timeoutSet)      timeoutQ   <= 1'b1;
    end
  end

  assign inst_count  = instCount;
  assign cycle_count = cycleCount;
  assign overflow    = overflowQ;
  assign timeout     = timeoutQ;
  assign done        = (state == S_DONE);

endmodule

// File: tb/tb_commit_trace_buffer.sv
// Directed bench for commit_trace_buffer: classification, FIFO/overflow, halt drain,
// watchdog timeout and reset during drain (second instance with CYCLE_LIMIT=20).
module tb_commit_trace_buffer;
  import commit_trace_pkg::*;

  localparam int DEPTH = 16;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  commit_trace_buffer_if bus();
  commit_trace_buffer_if bus2();

  logic [31:0] instCount, cycleCount, instCount2, cycleCount2;
  logic [4:0]  level, level2;
  logic        overflow, timeout, done, overflow2, timeout2, done2;

  commit_trace_buffer #(.DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .tr(bus),
    .inst_count(instCount), .cycle_count(cycleCount), .fifo_level(level),
    .overflow(overflow), .timeout(timeout), .done(done)
  );

  commit_trace_buffer #(.DEPTH(DEPTH), .CYCLE_LIMIT(20)) dut2 (
    .clk(clk), .rst_n(rst_n), .tr(bus2),
    .inst_count(instCount2), .cycle_count(cycleCount2), .fifo_level(level2),
    .overflow(overflow2), .timeout(timeout2), .done(done2)
  );

  int checks = 0;
  int failures = 0;

  task automatic checkVal(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idleInputs();
    bus.commit_valid = 0; bus.commit_pc = '0; bus.reg_write = 0; bus.write_reg = '0;
    bus.write_data = '0; bus.mem_read = 0; bus.mem_write = 0; bus.mem_addr = '0;
    bus.mem_data = '0; bus.halt = 0; bus.trace_ready = 0;
    bus2.commit_valid = 0; bus2.commit_pc = '0; bus2.reg_write = 0; bus2.write_reg = '0;
    bus2.write_data = '0; bus2.mem_read = 0; bus2.mem_write = 0; bus2.mem_addr = '0;
    bus2.mem_data = '0; bus2.halt = 0; bus2.trace_ready = 0;
  endtask

  task automatic doReset();
    idleInputs();
    rst_n = 0;
    tick();
    tick();
    rst_n = 1;
  endtask

  task automatic commit(input logic [15:0] pc, input logic rw, input logic [3:0] wreg,
                        input logic [15:0] wdata, input logic mr, input logic mw,
                        input logic [15:0] maddr, input logic [15:0] mdata, input logic h);
    bus.commit_pc = pc; bus.reg_write = rw; bus.write_reg = wreg; bus.write_data = wdata;
    bus.mem_read = mr; bus.mem_write = mw; bus.mem_addr = maddr; bus.mem_data = mdata;
    bus.halt = h; bus.commit_valid = 1;
    tick();
    bus.commit_valid = 0; bus.halt = 0;
  endtask

  initial begin
    int k;

    // Reset state
    idleInputs();
    rst_n = 0;
    tick();
    checkVal("rst_valid", bus.trace_valid, 0);
    checkVal("rst_inst", instCount, 0);
    checkVal("rst_cycle", cycleCount, 0);
    checkVal("rst_level", level, 0);
    checkVal("rst_flags", {overflow, timeout, done}, 0);

    // Single REG commit
    doReset();
    bus.trace_ready = 1;
    commit(16'h0002, 1, 4'd3, 16'h00AB, 0, 0, 16'h0, 16'h0, 0);
    checkVal("reg_valid", bus.trace_valid, 1);
    checkVal("reg_kind", bus.trace_kind, 1);
    checkVal("reg_inum", bus.trace_inum, 0);
    checkVal("reg_reg", bus.trace_reg, 3);
    checkVal("reg_value", bus.trace_value, 16'h00AB);
    checkVal("reg_pc", bus.trace_pc, 16'h0002);
    checkVal("reg_addr", bus.trace_addr, 0);
    checkVal("reg_inst", instCount, 1);
    tick();
    checkVal("reg_popped", bus.trace_valid, 0);

    // LOAD, STORE, then load+store conflict resolving to STORE
    doReset();
    bus.trace_ready = 1;
    commit(16'h0004, 1, 4'd5, 16'h1234, 1, 0, 16'h0040, 16'h0, 0);
    checkVal("ld_kind", bus.trace_kind, 2);
    checkVal("ld_inum", bus.trace_inum, 0);
    checkVal("ld_reg", bus.trace_reg, 5);
    checkVal("ld_value", bus.trace_value, 16'h1234);
    checkVal("ld_addr", bus.trace_addr, 16'h0040);
    commit(16'h0006, 0, 4'd0, 16'h0, 0, 1, 16'h0042, 16'hBEEF, 0);
    checkVal("st_kind", bus.trace_kind, 3);
    checkVal("st_inum", bus.trace_inum, 1);
    checkVal("st_reg", bus.trace_reg, 0);
    checkVal("st_value", bus.trace_value, 16'hBEEF);
    checkVal("st_addr", bus.trace_addr, 16'h0042);
    checkVal("st_level", level, 1);
    commit(16'h0008, 1, 4'd7, 16'h9999, 1, 1, 16'h0044, 16'h5555, 0);
    checkVal("prio_kind", bus.trace_kind, 3);
    checkVal("prio_reg", bus.trace_reg, 0);
    checkVal("prio_value", bus.trace_value, 16'h5555);

    // Overflow: DEPTH+2 commits with consumer stalled
    doReset();
    for (int i = 0; i < DEPTH + 2; i++) commit(16'(2 * i), 0, 0, 0, 0, 0, 0, 0, 0);
    checkVal("ovf_level", level, DEPTH);
    checkVal("ovf_flag", overflow, 1);
    checkVal("ovf_inst", instCount, DEPTH + 2);
    bus.trace_ready = 1;
    for (int i = 0; i < DEPTH; i++) begin
      checkVal($sformatf("ovf_drain_inum%0d", i), bus.trace_inum, i);
      tick();
    end
    checkVal("ovf_empty", {bus.trace_valid, level}, 0);

    // Full FIFO with simultaneous pop and push: nothing dropped
    doReset();
    for (int i = 0; i < DEPTH; i++) commit(16'(2 * i), 0, 0, 0, 0, 0, 0, 0, 0);
    checkVal("full_level", level, DEPTH);
    bus.trace_ready = 1;
    commit(16'h0100, 0, 0, 0, 0, 0, 0, 0, 0);
    bus.trace_ready = 0;
    checkVal("pp_level", level, DEPTH);
    checkVal("pp_overflow", overflow, 0);
    checkVal("pp_head", bus.trace_inum, 1);
    checkVal("pp_inst", instCount, DEPTH + 1);

    // HALT at inum 7 with 3 queued; later commits ignored
    doReset();
    for (int i = 0; i < 7; i++) commit(16'(16'h0010 + 2 * i), 0, 0, 0, 0, 0, 0, 0, 0);
    bus.trace_ready = 1;
    repeat (4) tick();
    bus.trace_ready = 0;
    checkVal("halt_pre_level", level, 3);
    commit(16'h0080, 0, 0, 0, 0, 1, 16'h0050, 16'h7777, 1);
    commit(16'h0082, 1, 4'd2, 16'h1111, 0, 0, 0, 0, 0);
    commit(16'h0084, 1, 4'd2, 16'h2222, 0, 0, 0, 0, 0);
    checkVal("halt_level", level, 4);
    checkVal("halt_inst", instCount, 8);
    bus.trace_ready = 1;
    for (int j = 0; j < 4; j++) begin
      checkVal($sformatf("halt_drain_inum%0d", j), bus.trace_inum, 4 + j);
      if (j == 3) begin
        checkVal("halt_last_kind", bus.trace_kind, 4);
        checkVal("halt_last_pc", bus.trace_pc, 16'h0080);
      end
      tick();
    end
    k = 0;
    while (!done && k < 10) begin
      tick();
      k++;
    end
    checkVal("halt_done", done, 1);
    checkVal("halt_valid_off", bus.trace_valid, 0);
    checkVal("halt_inst_final", instCount, 8);
    checkVal("halt_cycle_held", cycleCount, 12);
    checkVal("halt_no_timeout", timeout, 0);

    // Watchdog with CYCLE_LIMIT=20
    doReset();
    bus2.trace_ready = 1;
    repeat (19) tick();
    checkVal("wd_cycle19", cycleCount2, 19);
    checkVal("wd_before", timeout2, 0);
    tick();
    checkVal("wd_cycle20", cycleCount2, 20);
    checkVal("wd_timeout", timeout2, 1);
    checkVal("wd_not_done", done2, 0);
    tick();
    checkVal("wd_done", done2, 1);
    tick();
    checkVal("wd_cycle_held", cycleCount2, 20);

    // Reset asserted while draining after a timeout
    doReset();
    bus2.commit_valid = 1;
    for (int i = 0; i < 3; i++) begin
      bus2.commit_pc = 16'(16'h0200 + 2 * i);
      tick();
    end
    bus2.commit_valid = 0;
    repeat (17) tick();
    checkVal("md_timeout", timeout2, 1);
    checkVal("md_level", level2, 3);
    checkVal("md_valid", bus2.trace_valid, 1);
    checkVal("md_inst", instCount2, 3);
    rst_n = 0;
    #1;
    checkVal("md_rst_valid", bus2.trace_valid, 0);
    checkVal("md_rst_level", level2, 0);
    checkVal("md_rst_counts", {instCount2, cycleCount2}, 0);
    checkVal("md_rst_flags", {overflow2, timeout2, done2}, 0);
    checkVal("md_rst_fields", {bus2.trace_inum, bus2.trace_pc, bus2.trace_kind}, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
